// File: rtl/button_event_arbiter.sv
// rtl/button_event_arbiter.sv - round-robin arbiter that queues single-cycle button presses into an event FIFO
module button_event_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    req_i,
  output logic                          evt_valid_o,
  output logic [1:0]                    evt_code_o,
  input  logic                          evt_ready_i,
  output logic [3:0]                    pending_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          drop_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [3:0]    pending;
  logic [1:0]    last_grant;
  logic [1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          drop;

  logic          pop;
  logic          space;
  logic          found;
  logic          gnt_valid;
  logic [1:0]    gnt_code;
  logic [1:0]    idx;
  logic [3:0]    gnt_onehot;
  logic [3:0]    pending_next;
  logic          drop_next;

  always_comb begin
    pop       = (count != '0) && evt_ready_i;
    space     = (count < CW'(FIFO_DEPTH)) || pop;
    found     = 1'b0;
    gnt_code  = 2'd0;
    idx       = 2'd0;
    // Search begins one past the last winner and wraps, so every button gets a turn.
    for (int k = 1; k <= 4; k++) begin
      idx = last_grant + 2'(k);
      if (!found && pending[idx]) begin
        found    = 1'b1;
        gnt_code = idx;
      end
    end
    gnt_valid    = found && space;
    gnt_onehot   = gnt_valid ? (4'b0001 << gnt_code) : 4'b0000;
    // A press on a button being granted this cycle is a fresh press, not a merge.
    pending_next = (pending & ~gnt_onehot) | req_i;
    drop_next    = |(req_i & pending & ~gnt_onehot);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending    <= 4'b0000;
      last_grant <= 2'd3;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      drop       <= 1'b0;
    end else begin
      pending <= pending_next;
      drop    <= drop_next;
      count   <= count + CW'(gnt_valid) - CW'(pop);
      if (gnt_valid) begin
        last_grant <= gnt_code;
        wr_ptr     <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && gnt_valid) begin
      mem[wr_ptr] <= gnt_code;
    end
  end

  assign evt_valid_o = (count != '0);
  assign evt_code_o  = (count != '0) ? mem[rd_ptr] : 2'd0;
  assign pending_o   = pending;
  assign count_o     = count;
  assign drop_o      = drop;

endmodule

// File: tb/tb_button_event_arbiter.sv
// tb/tb_button_event_arbiter.sv - directed self-checking bench for button_event_arbiter
module tb_button_event_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_i;
    logic       evt_valid_o;
    logic [1:0] evt_code_o;
    logic       evt_ready_i;
    logic [3:0] pending_o;
    logic [2:0] count_o;
    logic       drop_o;

    int tests = 0;
    int fails = 0;
    logic done = 1'b0;

    button_event_arbiter #(.FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .evt_valid_o (evt_valid_o),
        .evt_code_o  (evt_code_o),
        .evt_ready_i (evt_ready_i),
        .pending_o   (pending_o),
        .count_o     (count_o),
        .drop_o      (drop_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        repeat (2000) @(posedge clk);
        if (!done) begin
            fails++;
            $error("FAIL timeout: stimulus did not complete within 2000 cycles");
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    initial begin
        rst = 1'b0; req_i = 4'b0000; evt_ready_i = 1'b0;
        step(); step();
        rst = 1'b1;
        check("rst_count", count_o, 3'd0);
        check("rst_valid", evt_valid_o, 1'b0);
        check("rst_pending", pending_o, 4'b0000);
        check("rst_drop", drop_o, 1'b0);
        check("rst_code", evt_code_o, 2'd0);

        req_i = 4'b0100; step();
        check("single_pending_k", pending_o, 4'b0100);
        check("single_valid_k", evt_valid_o, 1'b0);
        req_i = 4'b0000; step();
        check("single_valid_k1", evt_valid_o, 1'b1);
        check("single_code_k1", evt_code_o, 2'd2);
        check("single_count_k1", count_o, 3'd1);
        check("single_pending_k1", pending_o, 4'b0000);
        evt_ready_i = 1'b1; step();
        check("single_pop_count", count_o, 3'd0);
        step();
        check("empty_ready_count", count_o, 3'd0);
        evt_ready_i = 1'b0;

        rst = 1'b0; step(); rst = 1'b1;
        req_i = 4'b1111; evt_ready_i = 1'b1; step();
        check("all_pending", pending_o, 4'b1111);
        check("all_drop0", drop_o, 1'b0);
        req_i = 4'b0000; step();
        check("all_code0", evt_code_o, 2'd0);
        check("all_drop1", drop_o, 1'b0);
        step();
        check("all_code1", evt_code_o, 2'd1);
        check("all_count1", count_o, 3'd1);
        step();
        check("all_code2", evt_code_o, 2'd2);
        step();
        check("all_code3", evt_code_o, 2'd3);
        check("all_pending_done", pending_o, 4'b0000);
        step();
        check("all_empty", evt_valid_o, 1'b0);
        check("all_drop_end", drop_o, 1'b0);
        evt_ready_i = 1'b0;

        req_i = 4'b0010; step();
        req_i = 4'b0000; step();
        check("fair_setup_count", count_o, 3'd1);
        req_i = 4'b0011; step();
        check("fair_pending", pending_o, 4'b0011);
        req_i = 4'b0000; step();
        check("fair_first_pending", pending_o, 4'b0010);
        check("fair_first_count", count_o, 3'd2);
        step();
        check("fair_second_count", count_o, 3'd3);
        check("fair_second_pending", pending_o, 4'b0000);
        evt_ready_i = 1'b1;
        check("fair_head", evt_code_o, 2'd1);
        step();
        check("fair_q1", evt_code_o, 2'd0);
        step();
        check("fair_q2", evt_code_o, 2'd1);
        step();
        check("fair_drained", count_o, 3'd0);
        evt_ready_i = 1'b0;

        req_i = 4'b0001; step();
        req_i = 4'b0010; step();
        req_i = 4'b0100; step();
        req_i = 4'b1000; step();
        req_i = 4'b0001; step();
        req_i = 4'b0000; step();
        check("full_count", count_o, 3'd4);
        check("full_pending", pending_o, 4'b0001);
        check("full_drop", drop_o, 1'b0);
        check("full_head", evt_code_o, 2'd0);
        step();
        check("full_hold_count", count_o, 3'd4);
        check("full_hold_pending", pending_o, 4'b0001);
        evt_ready_i = 1'b1; step();
        evt_ready_i = 1'b0;
        check("full_pop_count", count_o, 3'd4);
        check("full_pop_pending", pending_o, 4'b0000);
        check("full_pop_head", evt_code_o, 2'd1);

        req_i = 4'b0001; step();
        check("merge_pending1", pending_o, 4'b0001);
        check("merge_drop1", drop_o, 1'b0);
        step();
        check("merge_pending2", pending_o, 4'b0001);
        check("merge_drop2", drop_o, 1'b1);
        req_i = 4'b0000; step();
        check("merge_drop3", drop_o, 1'b0);
        check("merge_pending3", pending_o, 4'b0001);

        rst = 1'b0; step(); rst = 1'b1;
        req_i = 4'b0001; step();
        step();
        check("repress_pending", pending_o, 4'b0001);
        check("repress_count", count_o, 3'd1);
        check("repress_drop", drop_o, 1'b0);
        req_i = 4'b0000; step();
        check("repress_count2", count_o, 3'd2);

        rst = 1'b0; step(); rst = 1'b1;
        req_i = 4'b0111; step();
        req_i = 4'b0000; step(); step(); step();
        req_i = 4'b1010; step();
        check("midrst_pre_count", count_o, 3'd3);
        check("midrst_pre_pending", pending_o, 4'b1010);
        rst = 1'b0; req_i = 4'b1111; evt_ready_i = 1'b1; step();
        check("midrst_valid", evt_valid_o, 1'b0);
        check("midrst_count", count_o, 3'd0);
        check("midrst_pending", pending_o, 4'b0000);
        check("midrst_drop", drop_o, 1'b0);
        rst = 1'b1; req_i = 4'b0000; evt_ready_i = 1'b0; step();
        check("postrst_count", count_o, 3'd0);
        check("postrst_pending", pending_o, 4'b0000);
        check("postrst_code", evt_code_o, 2'd0);

        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
